puf_challenge_sequencer: RTL and testbench
==========================================

// Module: puf_challenge_sequencer
// PURPOSE
//   Initiator side of the RO-PUF challenge/response interface. Walks challenges
//   0..NUM_CHAL-1, drives start/challenge into the PUF top, samples each 2-bit
//   response and assembles a RESP_W-bit word. ENROLL mode stores the word as the
//   reference; VERIFY mode reports its Hamming distance to the reference and a match flag.
// PARAMETERS
//   NUM_CHAL      8    challenges per run, 1..8 (challenge bus is 3 bits)
//   MEAS_CYCLES   256  cycles puf_start is held high per challenge, >=1
//   SAMPLE_DELAY  4    cycles after puf_start falls before puf_response is sampled, >=1
//   GAP_CYCLES    2    cycles puf_start is low, challenge stable, before MEASURE, >=1
//   THRESH        2    max Hamming distance accepted as a match
//   RESP_W        16   derived = 2*NUM_CHAL; not to be overridden
// PORTS
//   clk            in   1       single clock, rising edge
//   rst            in   1       asynchronous, active-high reset
//   req            in   1       1-cycle run request; sampled only in IDLE
//   mode_enroll    in   1       captured with req: 1=ENROLL, 0=VERIFY
//   busy           out  1       high from the cycle after accepted req until DONE exits
//   puf_start      out  1       to PUF start
//   puf_challenge  out  3       to PUF challenge
//   puf_response   in   2       from PUF puf_response
//   resp_word      out  RESP_W  assembled response; bits [2i+1:2i] = challenge i
//   hamming        out  5       popcount(resp_word ^ ref) for last VERIFY run
//   match          out  1       result of last run
//   ref_valid      out  1       reference has been enrolled since reset
//   valid          out  1       1-cycle pulse: resp_word/hamming/match updated
// BEHAVIOUR
//   Reset (async): state=IDLE; puf_start=0, puf_challenge=0, busy=0, valid=0,
//     match=0, ref_valid=0, resp_word=0, hamming=0, reference=0, counters=0.
//   All outputs registered. States and transitions:
//   IDLE:    req=1 -> capture mode, idx=0, clear resp_word shift -> ARM. Else stay.
//   ARM:     puf_challenge=idx, puf_start=0 for GAP_CYCLES cycles -> MEASURE.
//   MEASURE: puf_start=1 exactly MEAS_CYCLES cycles, challenge held -> SETTLE.
//   SETTLE:  puf_start=0 for SAMPLE_DELAY cycles -> SAMPLE.
//   SAMPLE:  one cycle; load puf_response into bits [2*idx+1:2*idx] of working word;
//            idx==NUM_CHAL-1 -> EVAL, else idx+1 -> ARM.
//   EVAL:    one cycle. ENROLL: reference<=word, ref_valid<=1, hamming<=0, match<=1.
//            VERIFY with ref_valid: hamming<=popcount(word^reference),
//              match<=(popcount<=THRESH). VERIFY without ref_valid: hamming<=RESP_W, match<=0.
//            resp_word<=word -> DONE.
//   DONE:    valid=1 for this one cycle -> IDLE.
//   - puf_challenge changes only in ARM; never while puf_start=1.
//   - Run latency req->valid: NUM_CHAL*(GAP+MEAS+SAMPLE_DELAY+1)+2 cycles.
//   - req while not IDLE is ignored (no queuing); req in the DONE cycle also ignored.
//   - Bits above 2*NUM_CHAL-1 of resp_word are 0 when NUM_CHAL<8.
//   - resp_word/hamming/match hold their values until the next EVAL.
//   - ENROLL overwrites any existing reference; reference cleared only by rst.
//   - rst mid-run: abort immediately, puf_start drops asynchronously, no valid pulse,
//     reference and ref_valid cleared.
//   - hamming width 5 covers 0..16; popcount computed combinationally on EVAL only.
// TESTING
//   1 rst then idle 20 cycles -> all outputs 0, puf_start never asserted.
//   2 req+mode_enroll=1, model returns chal[1:0] -> resp_word=16'hE4E4, match=1,
//     ref_valid=1, hamming=0, valid pulse at documented latency.
//   3 after 2, VERIFY with chal 3 response flipped 2'b11->2'b00 -> hamming=2, match=1;
//     with chal 3 and 7 both flipped -> hamming=4, match=0.
//   4 VERIFY straight after rst -> hamming=16, match=0, ref_valid=0.
//   5 req pulses during MEASURE and DONE -> ignored, exactly one valid per accepted req;
//     check puf_start high exactly MEAS_CYCLES per challenge, challenge stable meanwhile.
//   6 rst asserted mid-MEASURE of chal 4 -> puf_start=0 same cycle, no valid,
//     ref_valid=0; next ENROLL run completes normally.

Source files
------------

// File: rtl/puf_challenge_sequencer_if.sv
// Host-side and PUF-side signals of the RO-PUF challenge sequencer.
// The sequencer (master) drives the PUF controls and result outputs.
interface puf_challenge_sequencer_if #(parameter int RESP_W = 16);
    logic              req;
    logic              mode_enroll;
    logic              busy;
    logic              puf_start;
    logic [2:0]        puf_challenge;
    logic [1:0]        puf_response;
    logic [RESP_W-1:0] resp_word;
    logic [4:0]        hamming;
    logic              match;
    logic              ref_valid;
    logic              valid;

    modport master (
        input  req, mode_enroll, puf_response,
        output busy, puf_start, puf_challenge, resp_word, hamming, match, ref_valid, valid
    );

    modport slave (
        output req, mode_enroll, puf_response,
        input  busy, puf_start, puf_challenge, resp_word, hamming, match, ref_valid, valid
    );
endinterface

// File: rtl/puf_challenge_sequencer.sv
// RO-PUF initiator: walks challenges, assembles the 2-bit responses into a word,
// and either enrolls it as reference or scores it against the reference.
module puf_challenge_sequencer #(
    parameter int NUM_CHAL     = 8,
    parameter int MEAS_CYCLES  = 256,
    parameter int SAMPLE_DELAY = 4,
    parameter int GAP_CYCLES   = 2,
    parameter int THRESH       = 2,
    parameter int RESP_W       = 2 * NUM_CHAL
) (
    input  logic                       clk,
    input  logic                       rst,
    puf_challenge_sequencer_if.master  bus
);
    localparam int CNT_MAX = (MEAS_CYCLES > GAP_CYCLES)
                             ? ((MEAS_CYCLES > SAMPLE_DELAY) ? MEAS_CYCLES : SAMPLE_DELAY)
                             : ((GAP_CYCLES > SAMPLE_DELAY) ? GAP_CYCLES : SAMPLE_DELAY);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, ARM, MEASURE, SETTLE, SAMPLE, EVAL, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic              mode_q, mode_d;
    logic [RESP_W-1:0] word_q, word_d;
    logic [RESP_W-1:0] ref_q, ref_d;
    logic              ref_valid_q, ref_valid_d;
    logic [RESP_W-1:0] resp_word_q, resp_word_d;
    logic [4:0]        hamming_q, hamming_d;
    logic              match_q, match_d;
    logic              busy_q, busy_d;
    logic              puf_start_q, puf_start_d;
    logic [2:0]        chal_q, chal_d;
    logic              valid_q, valid_d;
    logic [4:0]        pop;

    function automatic logic [4:0] popcnt(input logic [RESP_W-1:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < RESP_W; i++) c = c + 5'(v[i]);
        return c;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            mode_q      <= 1'b0;
            word_q      <= '0;
            ref_q       <= '0;
            ref_valid_q <= 1'b0;
            resp_word_q <= '0;
            hamming_q   <= '0;
            match_q     <= 1'b0;
            busy_q      <= 1'b0;
            puf_start_q <= 1'b0;
            chal_q      <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            mode_q      <= mode_d;
            word_q      <= word_d;
            ref_q       <= ref_d;
            ref_valid_q <= ref_valid_d;
            resp_word_q <= resp_word_d;
            hamming_q   <= hamming_d;
            match_q     <= match_d;
            busy_q      <= busy_d;
            puf_start_q <= puf_start_d;
            chal_q      <= chal_d;
            valid_q     <= valid_d;
        end
    end

    // Each timed state leaves when its cycle counter hits its length minus one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: if (bus.req) begin
                state_d = ARM;
                idx_d   = '0;
                cnt_d   = '0;
            end
            ARM: if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                state_d = MEASURE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            MEASURE: if (cnt_q == CNT_W'(MEAS_CYCLES - 1)) begin
                state_d = SETTLE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            SETTLE: if (cnt_q == CNT_W'(SAMPLE_DELAY - 1)) begin
                state_d = SAMPLE;
                cnt_d   = '0;
            end else cnt_d = cnt_q + 1'b1;
            SAMPLE: if (idx_q == 3'(NUM_CHAL - 1)) state_d = EVAL;
                    else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ARM;
                    end
            EVAL:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs are derived from the next state so they line up with it.
    always_comb begin
        mode_d      = mode_q;
        word_d      = word_q;
        ref_d       = ref_q;
        ref_valid_d = ref_valid_q;
        resp_word_d = resp_word_q;
        hamming_d   = hamming_q;
        match_d     = match_q;
        pop         = '0;
        busy_d      = (state_d != IDLE);
        puf_start_d = (state_d == MEASURE);
        valid_d     = (state_d == DONE);
        chal_d      = (state_d == ARM) ? idx_d : chal_q;
        case (state_q)
            IDLE: if (bus.req) begin
                mode_d = bus.mode_enroll;
                word_d = '0;
            end
            SAMPLE: word_d[int'(idx_q) * 2 +: 2] = bus.puf_response;
            EVAL: begin
                resp_word_d = word_q;
                if (mode_q) begin
                    ref_d       = word_q;
                    ref_valid_d = 1'b1;
                    hamming_d   = '0;
                    match_d     = 1'b1;
                end else if (ref_valid_q) begin
                    pop       = popcnt(word_q ^ ref_q);
                    hamming_d = pop;
                    match_d   = (pop <= 5'(THRESH));
                end else begin
                    hamming_d = 5'(RESP_W);
                    match_d   = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy          = busy_q;
    assign bus.puf_start     = puf_start_q;
    assign bus.puf_challenge = chal_q;
    assign bus.resp_word     = resp_word_q;
    assign bus.hamming       = hamming_q;
    assign bus.match         = match_q;
    assign bus.ref_valid     = ref_valid_q;
    assign bus.valid         = valid_q;
endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer with a behavioural PUF whose
// response is chal[1:0] optionally XORed with a per-challenge flip mask.
module tb_puf_challenge_sequencer;
    localparam int NC   = 8;
    localparam int MEAS = 20;
    localparam int SD   = 4;
    localparam int GAP  = 2;
    localparam int TH   = 2;
    localparam int RW   = 2 * NC;
    localparam int LAT  = NC * (GAP + MEAS + SD + 1) + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    puf_challenge_sequencer_if #(.RESP_W(RW)) bus ();

    puf_challenge_sequencer #(
        .NUM_CHAL(NC), .MEAS_CYCLES(MEAS), .SAMPLE_DELAY(SD),
        .GAP_CYCLES(GAP), .THRESH(TH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] flip [8];
    assign bus.puf_response = bus.puf_challenge[1:0] ^ flip[bus.puf_challenge];

    typedef struct {
        logic [RW-1:0] w;
        logic [4:0]    ham;
        logic          m;
        logic          rv;
        int            at;
    } exp_t;
    exp_t q[$];

    logic [RW-1:0] ref_w;
    logic          ref_ok;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issue one accepted request and push the model's expected result.
    task automatic start_run(input bit enr);
        exp_t e;
        logic [RW-1:0] w;
        w = '0;
        for (int i = 0; i < NC; i++) w[2*i +: 2] = 2'(i) ^ flip[i];
        e.w = w;
        if (enr) begin
            e.ham = 5'd0; e.m = 1'b1; ref_w = w; ref_ok = 1'b1;
        end else if (ref_ok) begin
            e.ham = 5'($countones(w ^ ref_w)); e.m = (e.ham <= 5'(TH));
        end else begin
            e.ham = 5'(RW); e.m = 1'b0;
        end
        e.rv = ref_ok;
        @(posedge clk); #1;
        bus.mode_enroll = enr;
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        e.at = cyc + LAT - 1;
        q.push_back(e);
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (q.size() != 0 && n < maxc) begin
            @(posedge clk); n++;
        end
        chk("run_timeout", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: MEASURE pulse length, challenge stability, and scoreboard pops on valid.
    initial begin
        int run;
        logic [2:0] run_chal;
        exp_t e;
        run = 0;
        run_chal = '0;
        forever begin
            @(negedge clk);
            if (rst) run = 0;
            else begin
                if (bus.puf_start) begin
                    if (run > 0) chk("chal_stable", bus.puf_challenge, run_chal);
                    else run_chal = bus.puf_challenge;
                    run++;
                end else if (run > 0) begin
                    chk("meas_len", run, MEAS);
                    run = 0;
                end
                if (bus.valid) begin
                    if (q.size() == 0) chk("spurious_valid", bus.valid, 0);
                    else begin
                        e = q.pop_front();
                        chk("resp_word", bus.resp_word, e.w);
                        chk("hamming", bus.hamming, e.ham);
                        chk("match", bus.match, e.m);
                        chk("ref_valid", bus.ref_valid, e.rv);
                        chk("latency", cyc, e.at);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.req = 1'b0;
        bus.mode_enroll = 1'b0;
        for (int i = 0; i < 8; i++) flip[i] = 2'b00;
        ref_w = '0;
        ref_ok = 1'b0;

        // reset state and quiet idle
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_match", bus.match, 0);
        chk("rst_ref_valid", bus.ref_valid, 0);
        chk("rst_resp_word", bus.resp_word, 0);
        chk("rst_hamming", bus.hamming, 0);
        chk("rst_chal", bus.puf_challenge, 0);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            chk("idle_start", bus.puf_start, 0);
        end

        // verify before any enrollment
        start_run(1'b0);
        wait_idle(LAT + 20);

        // enroll, then verify with one and two flipped challenges
        start_run(1'b1);
        wait_idle(LAT + 20);
        flip[3] = 2'b11;
        start_run(1'b0);
        wait_idle(LAT + 20);
        flip[7] = 2'b11;
        start_run(1'b0);
        wait_idle(LAT + 20);
        flip[3] = 2'b00;
        flip[7] = 2'b00;

        // requests during MEASURE and DONE must be ignored
        start_run(1'b0);
        n = 0;
        while (!bus.puf_start && n < 100) begin @(posedge clk); #1; n++; end
        chk("saw_measure", bus.puf_start, 1);
        bus.mode_enroll = 1'b1;
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        n = 0;
        while (!bus.valid && n < LAT + 20) begin @(posedge clk); #1; n++; end
        chk("saw_valid", bus.valid, 1);
        bus.req = 1'b1;
        @(posedge clk); #1;
        bus.req = 1'b0;
        repeat (LAT + 20) @(posedge clk);
        #1;
        chk("busy_after_ignored", bus.busy, 0);
        chk("queue_empty", q.size(), 0);

        // reset during MEASURE of challenge 4
        start_run(1'b1);
        n = 0;
        while (!(bus.puf_start && bus.puf_challenge == 3'd4) && n < LAT + 20) begin
            @(posedge clk); #1; n++;
        end
        chk("reach_chal4", bus.puf_challenge, 4);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort_start", bus.puf_start, 0);
        chk("abort_ref_valid", bus.ref_valid, 0);
        chk("abort_busy", bus.busy, 0);
        q.delete();
        ref_ok = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("post_abort_valid", bus.valid, 0);
        start_run(1'b1);
        wait_idle(LAT + 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
